fsk_stream_modulator: RTL
=========================

Name: fsk_stream_modulator

Overview:
- Parametrised successor to the fixed-width, free-running FSK modulator in the BLE TX path.
- Accepts packet bytes over a valid/ready stream and serialises them LSB-first (BLE bit order) at SPS samples per symbol.
- Each bit steers a phase-accumulator NCO to CENTER_STEP ± DEV_STEP; the block emits signed I/Q samples with a valid strobe.
- Adds framing (last byte), a one-byte skid buffer, underrun detection and clean return to idle with phase reset.

Parameters:
- SIN_W, 8: signed width of FSK_I/FSK_Q; peak amplitude is 2^(SIN_W-1)-1.
- PHASE_W, 16: phase accumulator width; wraps modulo 2^PHASE_W.
- LUT_AW, 6: quarter-wave sine ROM address width (2^LUT_AW entries); phase index = top LUT_AW+2 accumulator bits.
- SPS, 4: samples (clocks) per symbol, >=2.
- DEV_STEP, 4096: frequency-deviation phase increment.
- CENTER_STEP, 0: carrier/IF phase increment, two's complement.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- s_data  in  8  packet byte
- s_valid  in  1  s_data valid
- s_last  in  1  byte is last of packet; qualified by s_valid
- s_ready  out  1  block can accept a byte this cycle
- FSK_I  out  SIN_W  signed in-phase sample, cos(phase)
- FSK_Q  out  SIN_W  signed quadrature sample, sin(phase)
- o_valid  out  1  FSK_I/FSK_Q hold a modulated sample
- sym_strobe  out  1  aligned with o_valid; marks the first sample of each symbol
- busy  out  1  RUN state or samples still in the pipeline
- underrun  out  1  one-cycle pulse when the data stream starves mid-packet

Behaviour:
- Reset (rst=1 at posedge): state IDLE, accumulator=0, hold buffer empty, all pipeline valids cleared. Outputs: s_ready=0 during reset (1 from the first cycle after), FSK_I=FSK_Q=0, o_valid=0, sym_strobe=0, busy=0, underrun=0. Reset mid-packet aborts immediately; no further samples are emitted.
- Hold buffer: one byte plus last flag. s_ready = !hold_full. A transfer occurs when s_valid && s_ready. A same-cycle load and drain is legal: the buffer stays full with the new byte.
- States:
  - IDLE: accumulator held at 0. When hold_full, move the byte into the shift register, set bit_cnt=0, samp_cnt=0, go to RUN.
  - RUN, each cycle:
    - inc = CENTER_STEP + (bit ? DEV_STEP : -DEV_STEP), computed PHASE_W-bit wrapping.
    - The current accumulator value is sent to the sample pipeline, then acc <= acc+inc. The first sample of a packet therefore has phase 0.
    - samp_cnt counts 0..SPS-1. At SPS-1 the shift register advances and bit_cnt increments.
  - End of byte (bit_cnt=7, samp_cnt=SPS-1):
    - Current byte flagged last: go to IDLE; accumulator resets to 0 on the next cycle.
    - Else if hold_full: reload from the buffer with no gap (continuous phase).
    - Else: pulse underrun, go to IDLE (packet truncated).
- Sample path: the ROM folds quadrants (sin from the quarter table with index mirror/negate; cos = sin(phase + quarter)).
  - Latency 2 cycles from accumulator sample to FSK_I/FSK_Q: ROM register, then fold/negate register.
  - o_valid and sym_strobe are delayed identically.
  - When o_valid=0, FSK_I and FSK_Q are forced to 0.
- busy = (state==RUN) || any pipeline valid.
- Output values: ROM entry k = round((2^(SIN_W-1)-1)·sin(2π·k/2^(LUT_AW+2))), symmetric saturation, never -2^(SIN_W-1).
- Packet timing: a packet of N bytes yields exactly 8·N·SPS consecutive o_valid cycles, starting 2 cycles after the RUN entry cycle.
- s_last on a byte accepted while the block is in RUN applies to that byte only.

Test Plan:
- Defaults. Send 0xFF with s_last=1 → 32 o_valid samples starting 2 cycles after RUN entry. Phase advances 4096 per sample (22.5°): first I=127/Q=0, 5th I=0/Q=127, 9th I=-127/Q=0. sym_strobe on samples 1,5,…,29. busy falls after sample 32. underrun never pulses.
- Send 0x00, last → Q sequence is the negated sequence of the 0xFF case, I identical. After 32 samples the accumulator returns to 0.
- Back-to-back 0x55, 0xAA(last), s_valid held high → 64 contiguous o_valid samples. Phase alternates +4096/-4096 per symbol with no discontinuity at the byte boundary. s_ready drops only while the buffer is full.
- Send 0x0F without last, then no further data → 32 samples, then underrun pulses for exactly one cycle at the last sample of the byte. State returns to IDLE and the next packet starts at phase 0 (I=127, Q=0).
- Assert rst for 1 cycle at sample 10 of a packet → no o_valid from the cycle after reset onward. All outputs read 0; s_ready=1 on the following cycle.
- CENTER_STEP=2048, DEV_STEP=1024, byte 0xF0 (bits 0,0,0,0,1,1,1,1) → per-sample increments 1024 for the first 16 samples, then 3072 for the next 16. Accumulator reads 16384 at sample 17.

Source files
------------

// File: rtl/fsk_stream_modulator.sv
// FSK stream modulator: accepts packet bytes over valid/ready, serialises
// them LSB-first at SPS samples per symbol and drives a phase-accumulator
// NCO at CENTER_STEP +/- DEV_STEP. Emits signed I/Q through a two-stage
// quarter-wave sine ROM pipeline with matching valid/strobe/underrun flags.
module fsk_stream_modulator #(
    parameter int SIN_W       = 8,
    parameter int PHASE_W     = 16,
    parameter int LUT_AW      = 6,
    parameter int SPS         = 4,
    parameter int DEV_STEP    = 4096,
    parameter int CENTER_STEP = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic signed [SIN_W-1:0] FSK_I,
    output logic signed [SIN_W-1:0] FSK_Q,
    output logic                    o_valid,
    output logic                    sym_strobe,
    output logic                    busy,
    output logic                    underrun
);

    localparam int PIDX_W = LUT_AW + 2;
    localparam int MAG_W  = SIN_W - 1;
    localparam int NQ     = 2 ** LUT_AW;
    localparam int PEAK   = 2 ** (SIN_W - 1) - 1;
    localparam int SC_W   = $clog2(SPS);

    localparam logic [SC_W-1:0]    SAMP_LAST = SC_W'(SPS - 1);
    localparam logic [PHASE_W-1:0] CSTEP     = PHASE_W'(CENTER_STEP);
    localparam logic [PHASE_W-1:0] DSTEP     = PHASE_W'(DEV_STEP);
    localparam logic [PHASE_W-1:0] INC_ONE   = CSTEP + DSTEP;
    localparam logic [PHASE_W-1:0] INC_ZERO  = CSTEP - DSTEP;
    localparam logic [PIDX_W-1:0]  QUARTER   = PIDX_W'(NQ);
    localparam real                TWO_PI    = 6.283185307179586;

    // ------------------------------------------------------------------
    // Rounding / saturation helpers used to build the quarter-wave table
    // ------------------------------------------------------------------
    function automatic int round_nearest(input real x);
        if (x >= 0.0)
            return $rtoi(x + 0.5);
        else
            return -$rtoi(0.5 - x);
    endfunction

    // Symmetric clamp: magnitude never exceeds PEAK, so negation can never
    // produce the most negative code.
    function automatic logic [MAG_W-1:0] sat_mag(input int v);
        if (v > PEAK)
            return MAG_W'(PEAK);
        else if (v < 0)
            return '0;
        else
            return MAG_W'(v);
    endfunction

    function automatic logic [MAG_W-1:0] rom_entry(input int k);
        real ang;
        real amp;
        ang = TWO_PI * real'(k) / real'(4 * NQ);
        amp = real'(PEAK) * $sin(ang);
        return sat_mag(round_nearest(amp));
    endfunction

    // Odd quadrants read the table mirrored; index 0 mirrored lands on the
    // quarter point itself, which lies one past the table and is the peak.
    function automatic logic [LUT_AW-1:0] rom_addr(input logic [PIDX_W-1:0] idx);
        logic [LUT_AW-1:0] r;
        r = idx[LUT_AW-1:0];
        return idx[LUT_AW] ? (LUT_AW'(0) - r) : r;
    endfunction

    function automatic logic at_peak(input logic [PIDX_W-1:0] idx);
        return idx[LUT_AW] && (idx[LUT_AW-1:0] == '0);
    endfunction

    function automatic logic signed [SIN_W-1:0] apply_sign(input logic [MAG_W-1:0] mag,
                                                           input logic              neg);
        logic signed [SIN_W-1:0] v;
        v = signed'({1'b0, mag});
        return neg ? -v : v;
    endfunction

    // ------------------------------------------------------------------
    // Quarter-wave sine table (constant)
    // ------------------------------------------------------------------
    logic [MAG_W-1:0] rom_tab [NQ];

    for (genvar k = 0; k < NQ; k++) begin : g_rom
        assign rom_tab[k] = rom_entry(k);
    end

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic               hold_full;
    logic [7:0]         hold_data;
    logic               hold_last;
    logic               load;

    logic [7:0]         sh_q;
    logic               cur_last;
    logic [2:0]         bit_cnt;
    logic [SC_W-1:0]    samp_cnt;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] inc;

    logic               take_byte;
    logic               end_byte;
    logic               go_idle;

    logic               vld_p0, sym_p0, unr_p0;
    logic [PIDX_W-1:0]  idx_s_p0, idx_c_p0;

    logic               vld_p1, sym_p1, unr_p1;
    logic [MAG_W-1:0]   mag_s_p1, mag_c_p1;
    logic               neg_s_p1, neg_c_p1;

    logic               vld_p2, sym_p2, unr_p2;
    logic signed [SIN_W-1:0] i_p2, q_p2;

    // ------------------------------------------------------------------
    // Input hold buffer
    // ------------------------------------------------------------------
    assign s_ready = !hold_full && !rst;
    assign load    = s_valid && s_ready;

    // Buffer occupancy: a same-cycle load and drain leaves it full.
    always_ff @(posedge clk) begin
        if (rst)
            hold_full <= 1'b0;
        else if (load)
            hold_full <= 1'b1;
        else if (take_byte)
            hold_full <= 1'b0;
    end

    // Buffer payload captured on every accepted transfer.
    always_ff @(posedge clk) begin
        if (load) begin
            hold_data <= s_data;
            hold_last <= s_last;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // Next-state and byte-sequencing decisions.
    always_comb begin
        state_d   = state_q;
        take_byte = 1'b0;
        unr_p0    = 1'b0;
        go_idle   = 1'b0;
        end_byte  = (bit_cnt == 3'd7) && (samp_cnt == SAMP_LAST);
        case (state_q)
            IDLE: begin
                if (hold_full) begin
                    take_byte = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (end_byte) begin
                    if (cur_last) begin
                        go_idle = 1'b1;
                        state_d = IDLE;
                    end else if (hold_full) begin
                        take_byte = 1'b1;
                    end else begin
                        unr_p0  = 1'b1;
                        go_idle = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, symbol counters and phase accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc      <= '0;
            bit_cnt  <= '0;
            samp_cnt <= '0;
            cur_last <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_byte) begin
                bit_cnt  <= '0;
                samp_cnt <= '0;
                cur_last <= hold_last;
            end else if (state_q == RUN) begin
                if (samp_cnt == SAMP_LAST) begin
                    samp_cnt <= '0;
                    bit_cnt  <= bit_cnt + 3'd1;
                end else begin
                    samp_cnt <= samp_cnt + SC_W'(1);
                end
            end
            if ((state_q == RUN) && !go_idle)
                acc <= acc + inc;
            else
                acc <= '0;
        end
    end

    // Bit shift register: LSB is the current symbol.
    always_ff @(posedge clk) begin
        if (take_byte)
            sh_q <= hold_data;
        else if ((state_q == RUN) && (samp_cnt == SAMP_LAST))
            sh_q <= {1'b0, sh_q[7:1]};
    end

    assign inc = sh_q[0] ? INC_ONE : INC_ZERO;

    // ------------------------------------------------------------------
    // Stage p0: accumulator sample and phase indices
    // ------------------------------------------------------------------
    assign vld_p0   = (state_q == RUN);
    assign sym_p0   = vld_p0 && (samp_cnt == '0);
    assign idx_s_p0 = acc[PHASE_W-1 -: PIDX_W];
    assign idx_c_p0 = idx_s_p0 + QUARTER;

    // Stage p1 control: valid, symbol strobe and underrun flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            sym_p1 <= 1'b0;
            unr_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            sym_p1 <= sym_p0;
            unr_p1 <= unr_p0;
        end
    end

    // Stage p1 data: ROM magnitude lookup plus sign of the half-cycle.
    always_ff @(posedge clk) begin
        mag_s_p1 <= at_peak(idx_s_p0) ? MAG_W'(PEAK) : rom_tab[rom_addr(idx_s_p0)];
        mag_c_p1 <= at_peak(idx_c_p0) ? MAG_W'(PEAK) : rom_tab[rom_addr(idx_c_p0)];
        neg_s_p1 <= idx_s_p0[PIDX_W-1];
        neg_c_p1 <= idx_c_p0[PIDX_W-1];
    end

    // Stage p2 control: flags aligned with the folded samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            sym_p2 <= 1'b0;
            unr_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            sym_p2 <= sym_p1;
            unr_p2 <= unr_p1;
        end
    end

    // Stage p2 data: apply quadrant sign to produce signed I/Q.
    always_ff @(posedge clk) begin
        i_p2 <= apply_sign(mag_c_p1, neg_c_p1);
        q_p2 <= apply_sign(mag_s_p1, neg_s_p1);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign FSK_I      = vld_p2 ? i_p2 : '0;
    assign FSK_Q      = vld_p2 ? q_p2 : '0;
    assign o_valid    = vld_p2;
    assign sym_strobe = sym_p2;
    assign underrun   = unr_p2;
    assign busy       = (state_q == RUN) || vld_p1 || vld_p2;

endmodule
